muldiv_seq: RTL

//   Multicycle MULT/DIV sequencer beside the ALU in the multicycle datapath.

---
 rtl/muldiv_pkg.sv | 16 +
 rtl/muldiv_seq_if.sv | 36 +++
 rtl/muldiv_step.sv | 45 ++++
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multicycle MULT/DIV sequencer.
//   state_e : sequencer FSM encoding (IDLE=0, RUN=1, FIX=2, DONE=3)
//   OP_MULT / OP_DIV : encoding of the op_div select
package muldiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_seq_if.sv
// Control-unit <-> MULT/DIV sequencer bundle.
//   master (control unit): drives start, op_div, a_in, b_in
//   slave  (sequencer)   : drives busy, done, div_zero, hi_out, lo_out, dbg_state
//
// Handshake: start is a request sampled on every rising clk edge. It is
// accepted only while the sequencer is idle or in its done cycle (busy == 0);
// while busy == 1 start is ignored. An accepted request always ends with
// exactly one single-cycle done pulse, after which hi_out/lo_out hold the
// result (div_zero marks a division by zero, in which case HI/LO keep their
// old contents). busy and done are never high together.
interface muldiv_seq_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             busy;
  logic             done;
  logic             div_zero;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  state_e           dbg_state;

  modport master (
    output start, op_div, a_in, b_in,
    input  busy, done, div_zero, hi_out, lo_out, dbg_state
  );

  modport slave (
    input  start, op_div, a_in, b_in,
    output busy, done, div_zero, hi_out, lo_out, dbg_state
  );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration of the MULT/DIV datapath on magnitudes.
//   op_div        : OP_MULT = shift-add, OP_DIV = restoring trial-subtract
//   acc_hi/acc_lo : current accumulator (MULT: product hi/lo, DIV: rem/quotient)
//   mag_a / mag_b : operand magnitudes (MULT uses mag_a, DIV uses mag_b)
//   nxt_hi/nxt_lo : accumulator after this iteration
module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             op_div,
  input  logic [WIDTH:0]   acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] mag_a,
  input  logic [WIDTH-1:0] mag_b,
  output logic [WIDTH:0]   nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH+1:0] sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   divisor;

  always_comb begin
    // MULT: add the multiplicand when the current multiplier bit (lo[0]) is
    // set, then shift the whole product one place right.
    sum     = {1'b0, acc_hi} + {2'b00, (acc_lo[0] ? mag_a : '0)};
    // DIV: bring the next dividend bit (quotient register MSB) into the remainder.
    shifted = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    divisor = {1'b0, mag_b};
    nxt_hi  = '0;
    nxt_lo  = '0;
    if (op_div == OP_MULT) begin
      nxt_hi = sum[WIDTH+1:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end else if (shifted >= divisor) begin
      nxt_hi = shifted - divisor;
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
    end else begin
      nxt_hi = shifted;
      nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multicycle signed MULT/DIV sequencer sitting beside the ALU.
//   clk   : rising-edge clock
//   reset : asynchronous, active-low (0 = reset)
//   bus   : muldiv_seq_if.slave (start/op_div/a_in/b_in in;
//           busy/done/div_zero/hi_out/lo_out/dbg_state out)
// Operands are reduced to magnitudes at capture, run through STEPS
// iterations of muldiv_step, and the signs are reapplied in the FIX state
// before HI/LO are written. HI/LO only change on that FIX edge.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input logic          clk,
  input logic          reset,
  muldiv_seq_if.slave  bus
);

  localparam int CW = $clog2(STEPS);
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

  state_e           state;
  logic [CW-1:0]    count;
  logic             op_q;
  logic             sign_a;
  logic             sign_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             busy_q;
  logic             done_q;
  logic             dz_q;

  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   fix_hi;
  logic [WIDTH-1:0]   fix_lo;

  // Magnitudes are unsigned, so the most negative value maps to 2^(WIDTH-1).
  always_comb begin
    abs_a = bus.a_in[WIDTH-1] ? -bus.a_in : bus.a_in;
    abs_b = bus.b_in[WIDTH-1] ? -bus.b_in : bus.b_in;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .op_div (op_q),
    .acc_hi (acc_hi),
    .acc_lo (acc_lo),
    .mag_a  (mag_a),
    .mag_b  (mag_b),
    .nxt_hi (step_hi),
    .nxt_lo (step_lo)
  );

  // Sign fix: product and quotient negate on differing signs; the remainder
  // follows the dividend, giving truncation toward zero. Overflow wraps.
  always_comb begin
    prod   = {acc_hi[WIDTH-1:0], acc_lo};
    prod_s = (sign_a ^ sign_b) ? -prod : prod;
    fix_hi = '0;
    fix_lo = '0;
    if (op_q == OP_MULT) begin
      fix_hi = prod_s[2*WIDTH-1:WIDTH];
      fix_lo = prod_s[WIDTH-1:0];
    end else begin
      fix_lo = (sign_a ^ sign_b) ? -acc_lo : acc_lo;
      fix_hi = sign_a ? -acc_hi[WIDTH-1:0] : acc_hi[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      count  <= '0;
      op_q   <= OP_MULT;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      case (state)
        ST_IDLE, ST_DONE: begin
          state <= ST_IDLE;
          if (bus.start) begin
            op_q   <= bus.op_div;
            sign_a <= bus.a_in[WIDTH-1];
            sign_b <= bus.b_in[WIDTH-1];
            mag_a  <= abs_a;
            mag_b  <= abs_b;
            count  <= '0;
            acc_hi <= '0;
            // MULT shifts the multiplier out of lo; DIV shifts the dividend out.
            acc_lo <= (bus.op_div == OP_DIV) ? abs_a : abs_b;
            if (bus.op_div == OP_DIV && bus.b_in == '0) begin
              state  <= ST_DONE;
              done_q <= 1'b1;
              dz_q   <= 1'b1;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == LAST) state <= ST_FIX;
        end
        ST_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          busy_q <= 1'b0;
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.div_zero  = dz_q;
  assign bus.hi_out    = hi_q;
  assign bus.lo_out    = lo_q;
  assign bus.dbg_state = state;

endmodule
